sap_reg_bank: RTL
=================

Name: sap_reg_bank

Overview:
Parametrised general-purpose register bank for the SAP-2 datapath. It replaces individual accumulator, B, temp and output registers with one bank of NUM_REGS registers, each WIDTH bits. The bank executes per-cycle register operations from the control sequencer: load, clear, increment, decrement, shift and swap. It drives the shared OR-combined bus and exports all contents in parallel to the ALU and display.

Parameters:
WIDTH, 8, data width of each register and of the bus
NUM_REGS, 4, number of registers (minimum 2; need not be a power of two)
OPERAND_W, 4, low bits kept on bus_o in operand-only read mode (1..WIDTH)

Ports:
clk_i  input  1  clock, rising edge
rstn_i  input  1  reset, asynchronous, active-low
sel_i  input  SEL_W=max(1,$clog2(NUM_REGS))  target register for the operation
op_i  input  3  operation code, see Behaviour
op_en_n_i  input  1  active-low execute strobe
bus_i  input  WIDTH  data from the shared bus (LOAD source)
rd_sel_i  input  SEL_W  read-port select, also the SWAP partner
oe_n_i  input  1  active-low bus output enable
operand_only_i  input  1  1 = bus_o carries only the low OPERAND_W bits
bus_o  output  WIDTH  bus contribution; all zeros when not enabled
parallel_o  output  NUM_REGS*WIDTH  register k at bits [k*WIDTH +: WIDTH]
zero_o  output  1  registered zero flag of the last flag-updating operation
carry_o  output  1  registered carry/borrow/shifted-out flag

Behaviour:
- Reset (rstn_i low, asynchronous): all registers, zero_o and carry_o go to 0 immediately. bus_o follows the combinational rule below and reads 0. Reset mid-operation aborts the operation; no partial update.
- An operation executes on the rising clk_i when op_en_n_i=0. With op_en_n_i=1 the bank holds everything.
- Op codes (R = reg[sel_i], P = reg[rd_sel_i]):
  - 000 HOLD: no change, flags unchanged.
  - 001 LOAD: R<=bus_i; zero=(bus_i==0); carry=0.
  - 010 CLEAR: R<=0; zero=1; carry=0.
  - 011 INC: R<=R+1 mod 2^WIDTH; carry=(R==all-ones); zero=(result==0).
  - 100 DEC: R<=R-1 mod 2^WIDTH; carry=(R==0), meaning borrow; zero=(result==0).
  - 101 SHL: R<={R[WIDTH-2:0],0}; carry=R[WIDTH-1]; zero from result.
  - 110 SHR: R<={0,R[WIDTH-1:1]}; carry=R[0]; zero from result.
  - 111 SWAP: R<=P and P<=R in the same edge; flags unchanged; if sel_i==rd_sel_i this is a no-op.
- Flags update only on executed ops other than HOLD and SWAP. They reflect exactly one op, with one-cycle latency (valid after the edge).
- Out-of-range select (sel_i>=NUM_REGS): the op is ignored and flags are unchanged. SWAP with either select out of range is ignored.
- bus_o is combinational:
  - (oe_n_i==0 and rd_sel_i<NUM_REGS) ? P : 0.
  - If operand_only_i=1, bits [WIDTH-1:OPERAND_W] are forced to 0.
- Read-during-op: bus_o and parallel_o show the pre-edge value in the cycle of the op and the new value from the next cycle.
- LOAD with sel_i==rd_sel_i and oe_n_i=0 is legal. The register captures bus_i, and the external bus is the sequencer's concern.
- parallel_o is combinational from register state. There is no extra latency.

Decomposition:
- Package sap_reg_pkg holds:
  - op code localparams (OP_HOLD..OP_SWAP)
  - the op_i width constant (3)
  - a function computing SEL_W from NUM_REGS
- Sub-module sap_reg_cell, instantiated NUM_REGS times:
  - inputs: current value, op, bus_i
  - outputs: next value, zero, carry
  - purely combinational per-op next-state logic
- The bank owns the state flops, SWAP routing, select decode, flag flops and bus_o muxing.

Test Plan:
- Reset: load 8'hA5 into every register, then pulse rstn_i low between clock edges -> all parallel_o slices 0, zero_o=0, carry_o=0, with no clock required.
- LOAD/read: LOAD 8'h3C into reg2; rd_sel_i=2, oe_n_i=0 -> bus_o=8'h3C next cycle. With operand_only_i=1 -> bus_o=8'h0C. With oe_n_i=1 -> bus_o=8'h00.
- INC wrap: reg1=8'hFF, INC -> reg1=8'h00, carry_o=1, zero_o=1. Repeat INC -> reg1=8'h01, carry_o=0, zero_o=0.
- DEC/shift: reg0=8'h00, DEC -> 8'hFF, carry_o=1. Then SHL -> 8'hFE, carry_o=1. Then SHR -> 8'h7F, carry_o=0.
- SWAP: reg0=8'h11, reg3=8'h99, SWAP sel=0 rd=3 -> reg0=8'h99, reg3=8'h11, flags unchanged. SWAP sel=rd=1 -> reg1 unchanged.
- Gating/range: op_en_n_i=1 with LOAD -> no change. With NUM_REGS=3, LOAD sel_i=3 -> no register or flag change, and bus_o=0 for rd_sel_i=3.

Source files
------------

// File: rtl/sap_reg_pkg.sv
// Shared op codes and sizing helpers for the SAP-2 register bank.
package sap_reg_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_HOLD  = 3'd0;
   localparam logic [OP_W-1:0] OP_LOAD  = 3'd1;
   localparam logic [OP_W-1:0] OP_CLEAR = 3'd2;
   localparam logic [OP_W-1:0] OP_INC   = 3'd3;
   localparam logic [OP_W-1:0] OP_DEC   = 3'd4;
   localparam logic [OP_W-1:0] OP_SHL   = 3'd5;
   localparam logic [OP_W-1:0] OP_SHR   = 3'd6;
   localparam logic [OP_W-1:0] OP_SWAP  = 3'd7;

   // Select width never drops below one bit, even for a two-entry bank.
   function automatic int sel_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sap_reg_cell.sv
// Per-register next-state and flag logic; purely combinational.
module sap_reg_cell
   import sap_reg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] cur,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] nxt,
   output logic             zero,
   output logic             carry
);

   logic [WIDTH:0] inc;

   assign inc = {1'b0, cur} + (WIDTH+1)'(1);

   always_comb begin
      nxt   = cur;
      carry = 1'b0;
      case (op)
         OP_LOAD:  nxt = din;
         OP_CLEAR: nxt = '0;
         OP_INC: begin
            nxt   = inc[WIDTH-1:0];
            carry = inc[WIDTH];
         end
         OP_DEC: begin
            nxt   = cur - WIDTH'(1);
            carry = (cur == '0);
         end
         OP_SHL: begin
            nxt   = {cur[WIDTH-2:0], 1'b0};
            carry = cur[WIDTH-1];
         end
         OP_SHR: begin
            nxt   = {1'b0, cur[WIDTH-1:1]};
            carry = cur[0];
         end
         default: nxt = cur;
      endcase
   end

   // Only meaningful for flag-updating ops; the bank ignores it otherwise.
   assign zero = (nxt == '0);

endmodule

// File: rtl/sap_reg_bank.sv
// General-purpose register bank for the SAP-2 datapath: state, swap routing,
// flag flops and the OR-combined bus driver.
module sap_reg_bank
   import sap_reg_pkg::*;
#(
   parameter  int WIDTH     = 8,
   parameter  int NUM_REGS  = 4,
   parameter  int OPERAND_W = 4,
   localparam int SEL_W     = sel_w(NUM_REGS)
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic [SEL_W-1:0]          sel_i,
   input  logic [OP_W-1:0]           op_i,
   input  logic                      op_en_n_i,
   input  logic [WIDTH-1:0]          bus_i,
   input  logic [SEL_W-1:0]          rd_sel_i,
   input  logic                      oe_n_i,
   input  logic                      operand_only_i,
   output logic [WIDTH-1:0]          bus_o,
   output logic [NUM_REGS*WIDTH-1:0] parallel_o,
   output logic                      zero_o,
   output logic                      carry_o
);

   localparam logic [SEL_W:0] NREG = (SEL_W+1)'(NUM_REGS);

   logic [NUM_REGS-1:0][WIDTH-1:0] regs, nxt;
   logic [NUM_REGS-1:0]            zf, cf;
   logic [WIDTH-1:0]               r_val, p_val;
   logic                           r_zero, r_carry;
   logic                           sel_ok, rd_ok, exec, do_swap, do_cell;

   // Non-power-of-two banks leave select codes that must be ignored.
   assign sel_ok  = ({1'b0, sel_i} < NREG);
   assign rd_ok   = ({1'b0, rd_sel_i} < NREG);
   assign exec    = !op_en_n_i && sel_ok;
   assign do_swap = exec && rd_ok && (op_i == OP_SWAP);
   assign do_cell = exec && (op_i != OP_SWAP) && (op_i != OP_HOLD);

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_cell
      sap_reg_cell #(.WIDTH(WIDTH)) u_cell (
         .cur   (regs[k]),
         .op    (op_i),
         .din   (bus_i),
         .nxt   (nxt[k]),
         .zero  (zf[k]),
         .carry (cf[k])
      );
   end

   always_comb begin
      r_val   = '0;
      p_val   = '0;
      r_zero  = 1'b0;
      r_carry = 1'b0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (sel_i == SEL_W'(k)) begin
            r_val   = regs[k];
            r_zero  = zf[k];
            r_carry = cf[k];
         end
         if (rd_sel_i == SEL_W'(k)) p_val = regs[k];
      end
   end

   // Swap reads both sides pre-edge, so sel_i==rd_sel_i collapses to a hold.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         regs <= '0;
      end else begin
         for (int k = 0; k < NUM_REGS; k++) begin
            if (do_swap && sel_i == SEL_W'(k))
               regs[k] <= p_val;
            else if (do_swap && rd_sel_i == SEL_W'(k))
               regs[k] <= r_val;
            else if (do_cell && sel_i == SEL_W'(k))
               regs[k] <= nxt[k];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         zero_o  <= 1'b0;
         carry_o <= 1'b0;
      end else if (do_cell) begin
         zero_o  <= r_zero;
         carry_o <= r_carry;
      end
   end

   always_comb begin
      bus_o = (!oe_n_i && rd_ok) ? p_val : '0;
      if (operand_only_i)
         for (int i = OPERAND_W; i < WIDTH; i++) bus_o[i] = 1'b0;
   end

   assign parallel_o = regs;

endmodule
